// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// FSM state encoding and slice-indexing helpers.
package mp_add_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Width of a counter that addresses nwords slices (at least one bit).
    function automatic int idx_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

    // Bit position of the least-significant bit of slice idx.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with carry in and carry out; purely combinational.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             co_o
);

    logic [WIDTH:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = ci_i;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        co_o = c[WIDTH];
    end

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: walks WIDTH*NWORDS-bit operands one slice per clock,
// least-significant first, through one shared ripple_carry_adder with a chained carry flop.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sub,
    input  logic [WIDTH*NWORDS-1:0]  opa,
    input  logic [WIDTH*NWORDS-1:0]  opb,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH*NWORDS-1:0]  result,
    output logic                     carry_out
);

    localparam int N     = WIDTH * NWORDS;
    localparam int IDX_W = idx_width(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             sub_q;
    logic [N-1:0]     opa_q;
    logic [N-1:0]     opb_q;
    logic [N-1:0]     result_q;
    logic             cout_q;

    logic             accept;
    logic             last_slice;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign last_slice = (idx_q == LAST_IDX);

    // Subtract is a + ~b + 1: the inversion happens here, the +1 is the seeded carry flop.
    assign add_a = opa_q[slice_lsb(int'(idx_q), WIDTH) +: WIDTH];
    assign add_b = opb_q[slice_lsb(int'(idx_q), WIDTH) +: WIDTH] ^ {WIDTH{sub_q}};

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .ci_i  (carry_q),
        .sum_o (add_sum),
        .co_o  (add_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            opa_q   <= opa;
            opb_q   <= opb;
            sub_q   <= sub;
            carry_q <= sub;
            idx_q   <= '0;
        end else if (state_q == S_RUN) begin
            result_q[slice_lsb(int'(idx_q), WIDTH) +: WIDTH] <= add_sum;
            carry_q <= add_co;
            // Index parks on the last slice; the next accept rewinds it.
            if (last_slice) begin
                cout_q <= add_co;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign result    = result_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Scoreboard bench for mp_add_sequencer: directed cases plus random add/subtract traffic.
module tb_mp_add_sequencer;

    localparam int WIDTH  = 4;
    localparam int NWORDS = 4;
    localparam int N      = WIDTH * NWORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry_out;

    typedef struct {
        logic [N-1:0] res;
        logic         co;
        int           acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    mp_add_sequencer #(
        .WIDTH  (WIDTH),
        .NWORDS (NWORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .opa       (opa),
        .opb       (opb),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole N-bit operands.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic s, input int acc);
        exp_t   e;
        longint ai = longint'(a);
        longint bi = longint'(b);
        longint full = longint'(1) << N;
        if (!s) begin
            e.res = N'(ai + bi);
            e.co  = ((ai + bi) >= full);
        end else begin
            e.res = N'(ai - bi + full);
            e.co  = (ai >= bi);
        end
        e.acc = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                chk("busy_len", busy_cnt, NWORDS);
                busy_cnt = 0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done pulse", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("result", result, mon_e.res);
                    chk("carry_out", carry_out, mon_e.co);
                    chk("latency", cyc - mon_e.acc, NWORDS + 1);
                end
            end
        end
    end

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        @(negedge clk);
        opa   = a;
        opb   = b;
        sub   = s;
        start = 1'b1;
        q.push_back(model(a, b, s, cyc));
        @(negedge clk);
        start = 1'b0;
        opa   = N'($urandom);
        opb   = N'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding after %0d cycles, expected 0", q.size(), n);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        opa   = '0;
        opb   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        rst = 1'b0;

        issue(16'h1234, 16'h0FF0, 1'b0);
        drain();
        issue(16'hFFFF, 16'h0001, 1'b0);
        drain();
        issue(16'h0001, 16'h0002, 1'b1);
        drain();

        // start pulsed during RUN cycles 2 and 3 must be ignored
        issue(16'h1234, 16'h0FF0, 1'b0);
        @(negedge clk);
        opa = 16'hAAAA; opb = 16'h5555; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (2) @(negedge clk);
        chk("ignored_start_result", result, 16'h2224);
        chk("ignored_start_carry", carry_out, 0);

        // back-to-back accept in the done cycle
        issue(16'h0010, 16'h0020, 1'b0);
        begin
            int n = 0;
            while (!done && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("b2b_done_seen", done, 1);
        end
        opa = 16'h0003; opb = 16'h0004; sub = 1'b0; start = 1'b1;
        q.push_back(model(16'h0003, 16'h0004, 1'b0, cyc));
        @(negedge clk);
        start = 1'b0;
        drain();
        chk("b2b_result", result, 16'h0007);

        // asynchronous reset in the middle of RUN
        issue(16'h1000, 16'h0001, 1'b1);
        drain();
        @(negedge clk);
        opa = 16'hABCD; opb = 16'h1111; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_result", result, 0);
        chk("arst_carry", carry_out, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        issue(16'h00FF, 16'h0001, 1'b0);
        drain();
        chk("post_rst_result", result, 16'h0100);
        chk("post_rst_carry", carry_out, 0);

        for (int i = 0; i < 40; i++) begin
            issue(N'($urandom), N'($urandom), 1'($urandom));
            drain();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
